// File: rtl/cnn_frame_driver.sv
// cnn_frame_driver: frame RAM + start/stream/wait/done sequencer for the lane CNN; CNN_DRV_TIMEOUT_EN adds a result-wait timeout.
module cnn_frame_driver #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int RESULT_W = 48,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [$clog2(IMG_W*IMG_H)-1:0]      wr_addr,
  input  logic [7:0]                          wr_data,
  input  logic                                go,
  output logic                                busy,
  output logic                                start_signal,
  output logic                                pixel_valid,
  output logic [7:0]                          pixel_in,
  input  logic                                final_result_valid,
  input  logic signed [RESULT_W-1:0]          final_lane_result,
  output logic                                result_valid,
  output logic signed [RESULT_W-1:0]          result_data,
  output logic                                timeout,
  output logic [15:0]                         frame_count
);
  localparam int N = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, rd_addr;
  logic [7:0] ram [N];
  logic [7:0] rd_q;
  logic start_q, start_d, pv_q, pv_d, rv_q, rv_d, busy_q, busy_d, last_pix;
  logic signed [RESULT_W-1:0] res_q, res_d;
  logic [15:0] fc_q, fc_d;
`ifdef CNN_DRV_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic to_q, to_d;
  assign timeout = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES == 0;
  assign timeout = 1'b0;
`endif
  assign last_pix = idx_q == AW'(N - 1);
  // Read one pixel ahead so the registered RAM output lines up with pixel_valid.
  assign rd_addr = (state_q == START) ? '0 : idx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    start_d = 1'b0;
    pv_d = 1'b0;
    rv_d = 1'b0;
    res_d = res_q;
    fc_d = fc_q;
`ifdef CNN_DRV_TIMEOUT_EN
    to_d = 1'b0;
    wait_d = wait_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = go ? START : IDLE;
        start_d = go;
      end
      START: begin
        state_d = STREAM;
        pv_d = 1'b1;
        idx_d = '0;
      end
      STREAM: begin
        state_d = last_pix ? WAIT : STREAM;
        pv_d = !last_pix;
        idx_d = last_pix ? idx_q : idx_q + 1'b1;
`ifdef CNN_DRV_TIMEOUT_EN
        wait_d = '0;
`endif
      end
      WAIT: begin
        if (final_result_valid) begin
          state_d = DONE;
          res_d = final_lane_result;
          rv_d = 1'b1;
          fc_d = fc_q + 1'b1;
        end
`ifdef CNN_DRV_TIMEOUT_EN
        else if (wait_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          to_d = 1'b1;
        end else wait_d = wait_q + 1'b1;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      start_q <= 1'b0;
      pv_q <= 1'b0;
      rv_q <= 1'b0;
      busy_q <= 1'b0;
      res_q <= '0;
      fc_q <= '0;
`ifdef CNN_DRV_TIMEOUT_EN
      wait_q <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      start_q <= start_d;
      pv_q <= pv_d;
      rv_q <= rv_d;
      busy_q <= busy_d;
      res_q <= res_d;
      fc_q <= fc_d;
`ifdef CNN_DRV_TIMEOUT_EN
      wait_q <= wait_d;
      to_q <= to_d;
`endif
    end
  end
  // Frame RAM keeps its contents across reset; host writes are locked out while busy.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) ram[wr_addr] <= wr_data;
    rd_q <= ram[rd_addr];
  end
  assign busy = busy_q;
  assign start_signal = start_q;
  assign pixel_valid = pv_q;
  assign pixel_in = pv_q ? rd_q : 8'd0;
  assign result_valid = rv_q;
  assign result_data = res_q;
  assign frame_count = fc_q;
endmodule
